// File: rtl/sw_input_port.sv
// Memory-mapped switch input port: sync, debounce, sticky W1C events, change counter.
// Define SW_IRQ_EN to add the MASK register and a registered interrupt line.
module sw_input_port #(
  parameter int unsigned N_SW            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_in,
  input  logic [31:0]     addr,
  input  logic [31:0]     writedata,
  input  logic            memwrite,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic            irq
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]         s1, s2, stable, stable_next, chg;
  logic [N_SW-1:0][CW-1:0] db_cnt, db_next;
  logic [N_SW-1:0]         evt, evt_next, clr;
  logic [15:0]             chg_cnt, chg_cnt_next;
  logic                    sel_state, sel_event, sel_count;

  // One-hot decode with fixed priority 4 > 5 > 6 > 7
  assign sel_state = addr[8] & addr[4];
  assign sel_event = addr[8] & ~addr[4] & addr[5];
  assign sel_count = addr[8] & ~addr[4] & ~addr[5] & addr[6];

  // Per-bit debounce: accept s2 once it has differed from stable for DEBOUNCE_CYCLES edges
  always_comb begin
    stable_next = stable;
    db_next     = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      if (s2[i] != stable[i]) begin
        if (db_cnt[i] == CNT_LAST) stable_next[i] = s2[i];
        else                       db_next[i] = db_cnt[i] + CW'(1);
      end
    end
  end

  assign chg          = stable ^ stable_next;
  assign clr          = (memwrite & sel_event) ? writedata[N_SW-1:0] : '0;
  assign evt_next     = (evt & ~clr) | chg;
  assign chg_cnt_next = ((memwrite & sel_count) ? 16'd0 : chg_cnt) + 16'(|chg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      stable  <= '0;
      db_cnt  <= '0;
      evt     <= '0;
      chg_cnt <= '0;
    end else begin
      s1      <= sw_in;
      s2      <= s1;
      stable  <= stable_next;
      db_cnt  <= db_next;
      evt     <= evt_next;
      chg_cnt <= chg_cnt_next;
    end
  end

`ifdef SW_IRQ_EN
  logic            sel_mask;
  logic [N_SW-1:0] mask, mask_next;

  assign sel_mask  = addr[8] & ~addr[4] & ~addr[5] & ~addr[6] & addr[7];
  assign mask_next = (memwrite & sel_mask) ? writedata[N_SW-1:0] : mask;
  assign hit       = addr[8] & (|addr[7:4]);

  // irq follows the next-state event/mask so it tracks set and clear with one register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      mask <= mask_next;
      irq  <= |(evt_next & mask_next);
    end
  end

  always_comb begin
    rdata = '0;
    if      (sel_state) rdata = 32'(stable);
    else if (sel_event) rdata = 32'(evt);
    else if (sel_count) rdata = 32'(chg_cnt);
    else if (sel_mask)  rdata = 32'(mask);
  end
`else
  assign hit = addr[8] & (|addr[6:4]);
  assign irq = 1'b0;

  always_comb begin
    rdata = '0;
    if      (sel_state) rdata = 32'(stable);
    else if (sel_event) rdata = 32'(evt);
    else if (sel_count) rdata = 32'(chg_cnt);
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[31:9], addr[7], addr[3:0], writedata};

endmodule

// File: tb/tb_sw_input_port.sv
// Bench for sw_input_port: directed scenarios plus randomized traffic against a window-based model.
module tb_sw_input_port;

  localparam int unsigned NSW = 10;
  localparam int unsigned DC  = 4;
`ifdef SW_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [NSW-1:0] sw_in;
  logic [31:0]    addr, writedata, rdata;
  logic           memwrite, hit, irq;

  sw_input_port #(.N_SW(NSW), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .addr(addr), .writedata(writedata),
    .memwrite(memwrite), .rdata(rdata), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: sw samples per edge; a level is accepted when the last DC synchronised samples all differ
  logic [NSW-1:0] samp[$];
  logic [NSW-1:0] m_stable, m_evt, m_mask;
  logic [15:0]    m_cnt;
  logic           m_irq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_stable = '0; m_evt = '0; m_mask = '0; m_cnt = '0; m_irq = 1'b0;
    samp.delete();
    samp.push_back('0);
    samp.push_back('0);
  endfunction

  function automatic void model_edge();
    logic [NSW-1:0] nxt, chg, clr;
    logic           clr_cnt;
    int             sz, first;
    nxt = m_stable;
    sz = samp.size();
    first = sz - 1 - int'(DC);
    if (first >= 0) begin
      for (int b = 0; b < int'(NSW); b++) begin
        bit all_diff = 1'b1;
        for (int k = first; k <= sz - 2; k++)
          if (samp[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_stable[b];
      end
    end
    chg = m_stable ^ nxt;
    clr = '0;
    clr_cnt = 1'b0;
    if (memwrite && addr[8]) begin
      if (addr[4]) ;
      else if (addr[5]) clr = writedata[NSW-1:0];
      else if (addr[6]) clr_cnt = 1'b1;
      else if (addr[7] && IRQ_EN) m_mask = writedata[NSW-1:0];
    end
    m_evt = (m_evt & ~clr) | chg;
    m_cnt = 16'((clr_cnt ? 0 : int'(m_cnt)) + ((chg != 0) ? 1 : 0));
    m_irq = IRQ_EN && (|(m_evt & m_mask));
    m_stable = nxt;
    samp.push_back(sw_in);
    if (samp.size() > int'(DC) + 4) void'(samp.pop_front());
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!a[8]) return 32'd0;
    if (a[4]) return 32'(m_stable);
    if (a[5]) return 32'(m_evt);
    if (a[6]) return 32'(m_cnt);
    if (a[7]) return IRQ_EN ? 32'(m_mask) : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return a[8] & (a[4] | a[5] | a[6] | (IRQ_EN & a[7]));
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] sa, d;
    logic        smw;
    sa = addr; smw = memwrite; memwrite = 1'b0;
    rd(32'h110, d); check_eq({tag, "_state"}, d, model_read(32'h110));
    rd(32'h120, d); check_eq({tag, "_event"}, d, model_read(32'h120));
    rd(32'h140, d); check_eq({tag, "_count"}, d, model_read(32'h140));
    rd(32'h180, d); check_eq({tag, "_mask"},  d, model_read(32'h180));
    check_eq({tag, "_irq"}, 32'(irq), 32'(m_irq));
    addr = sa; memwrite = smw;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    reset = 1'b1; sw_in = '0; addr = '0; writedata = '0; memwrite = 1'b0;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;

    // 1: reset state and an unmapped IO address
    rd(32'h110, d); check_eq("t1_state", d, 0);
    rd(32'h120, d); check_eq("t1_event", d, 0);
    rd(32'h140, d); check_eq("t1_count", d, 0);
    check_eq("t1_irq", 32'(irq), 0);
    rd(32'h104, d); check_eq("t1_rdata_104", d, 0);
    check_eq("t1_hit_104", 32'(hit), 0);

    // 2: accepted rise lands on edge DC+2
    sw_in = 10'h001;
    for (int e = 1; e <= 5; e++) begin
      tick();
      rd(32'h110, d); check_eq("t2_state_early", d, 0);
    end
    tick();
    rd(32'h110, d); check_eq("t2_state", d, 32'h001);
    rd(32'h120, d); check_eq("t2_event", d, 32'h001);
    rd(32'h140, d); check_eq("t2_count", d, 1);
    check_regs("t2");

    // 3: a 3-cycle glitch never gets accepted
    sw_in = 10'h009;
    repeat (3) tick();
    sw_in = 10'h001;
    repeat (8) begin tick(); check_regs("t3"); end
    rd(32'h110, d); check_eq("t3_state", d, 32'h001);
    rd(32'h120, d); check_eq("t3_event", d, 32'h001);
    rd(32'h140, d); check_eq("t3_count", d, 1);

    // 4: W1C in the same cycle as a new change on that bit; the set wins
    sw_in = 10'h000;
    repeat (5) tick();
    wr(32'h120, 32'h001);
    rd(32'h110, d); check_eq("t4_state", d, 0);
    rd(32'h120, d); check_eq("t4_event_set_wins", d, 32'h001);
    rd(32'h140, d); check_eq("t4_count", d, 2);
    wr(32'h120, 32'h001);
    rd(32'h120, d); check_eq("t4_event_cleared", d, 0);

    // 5: masked interrupt
    wr(32'h180, 32'h004);
    rd(32'h180, d); check_eq("t5_mask", d, IRQ_EN ? 32'h004 : 32'h0);
    check_eq("t5_hit_180", 32'(hit), 32'(IRQ_EN));
    sw_in = 10'h004;
    repeat (5) begin tick(); check_eq("t5_irq_early", 32'(irq), 0); end
    tick();
    rd(32'h120, d); check_eq("t5_event", d, 32'h004);
    check_eq("t5_irq_set", 32'(irq), 32'(IRQ_EN));
    wr(32'h120, 32'h004);
    check_eq("t5_irq_clear", 32'(irq), 0);
    check_regs("t5");

    // 6: reset mid-debounce aborts the count
    sw_in = 10'h002;
    repeat (4) tick();
    reset = 1'b1; model_reset();
    rd(32'h110, d); check_eq("t6_state_in_reset", d, 0);
    rd(32'h140, d); check_eq("t6_count_in_reset", d, 0);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      rd(32'h110, d); check_eq("t6_state_early", d, 0);
    end
    tick();
    rd(32'h110, d); check_eq("t6_state", d, 32'h002);
    rd(32'h120, d); check_eq("t6_event", d, 32'h002);
    rd(32'h140, d); check_eq("t6_count", d, 1);

    // 7: COUNT write coinciding with an increment, then plain clear; STATE write ignored
    sw_in = 10'h000;
    repeat (5) tick();
    wr(32'h140, 32'hFFFF_FFFF);
    rd(32'h140, d); check_eq("t7_count_wr_inc", d, 1);
    wr(32'h140, 32'h0);
    rd(32'h140, d); check_eq("t7_count_clear", d, 0);
    wr(32'h110, 32'h3FF);
    rd(32'h110, d); check_eq("t7_state_ro", d, 0);
    check_regs("t7");

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < int'(NSW); b++)
        if ($urandom_range(0, 7) == 0) sw_in[b] = ~sw_in[b];
      case ($urandom_range(0, 7))
        0: addr = 32'h110;
        1: addr = 32'h120;
        2: addr = 32'h140;
        3: addr = 32'h180;
        4: addr = 32'h100 | ($urandom & 32'hF0);
        5: addr = $urandom & 32'hF0;
        6: addr = $urandom;
        default: addr = 32'h104;
      endcase
      writedata = $urandom;
      memwrite = 1'b0;
      #1;
      check_eq("rnd_hit", 32'(hit), 32'(model_hit(addr)));
      check_eq("rnd_rdata", rdata, model_read(addr));
      memwrite = ($urandom_range(0, 3) == 0);
      tick();
      memwrite = 1'b0;
      check_regs("rnd");
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; model_reset();
        #1;
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
